// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - shared opcodes, sequencer states and ALU source codes
package td4_pkg;

   localparam logic [3:0] OP_ADD_A  = 4'b0000;
   localparam logic [3:0] OP_MOV_AB = 4'b0001;
   localparam logic [3:0] OP_IN_A   = 4'b0010;
   localparam logic [3:0] OP_MOV_A  = 4'b0011;
   localparam logic [3:0] OP_MOV_BA = 4'b0100;
   localparam logic [3:0] OP_ADD_B  = 4'b0101;
   localparam logic [3:0] OP_IN_B   = 4'b0110;
   localparam logic [3:0] OP_MOV_B  = 4'b0111;
   localparam logic [3:0] OP_OUT_B  = 4'b1001;
   localparam logic [3:0] OP_OUT_IM = 4'b1011;
   localparam logic [3:0] OP_JNC    = 4'b1110;
   localparam logic [3:0] OP_JMP    = 4'b1111;

   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   localparam logic [1:0] SRC_A    = 2'd0;
   localparam logic [1:0] SRC_B    = 2'd1;
   localparam logic [1:0] SRC_IN   = 2'd2;
   localparam logic [1:0] SRC_ZERO = 2'd3;

endpackage

// File: rtl/inst_decode.sv
// rtl/inst_decode.sv - combinational opcode decode for the 4-bit datapath
module inst_decode
   import td4_pkg::*;
(
   input  logic [3:0] op,
   input  logic       cflag,
   output logic       we_a,
   output logic       we_b,
   output logic       we_out,
   output logic [1:0] src_sel,
   output logic       jump_taken,
   output logic       illegal_op
);

   // Opcode to enables/source/jump; undefined opcodes behave as NOPs
   always_comb begin
      we_a       = 1'b0;
      we_b       = 1'b0;
      we_out     = 1'b0;
      src_sel    = SRC_ZERO;
      jump_taken = 1'b0;
      illegal_op = 1'b0;
      case (op)
         OP_ADD_A:  begin src_sel = SRC_A;    we_a   = 1'b1; end
         OP_ADD_B:  begin src_sel = SRC_B;    we_b   = 1'b1; end
         OP_MOV_A:  begin src_sel = SRC_ZERO; we_a   = 1'b1; end
         OP_MOV_B:  begin src_sel = SRC_ZERO; we_b   = 1'b1; end
         OP_MOV_AB: begin src_sel = SRC_B;    we_a   = 1'b1; end
         OP_MOV_BA: begin src_sel = SRC_A;    we_b   = 1'b1; end
         OP_IN_A:   begin src_sel = SRC_IN;   we_a   = 1'b1; end
         OP_IN_B:   begin src_sel = SRC_IN;   we_b   = 1'b1; end
         OP_OUT_B:  begin src_sel = SRC_B;    we_out = 1'b1; end
         OP_OUT_IM: begin src_sel = SRC_ZERO; we_out = 1'b1; end
         OP_JMP:    jump_taken = 1'b1;
         OP_JNC:    jump_taken = ~cflag;
         default:   illegal_op = 1'b1;
      endcase
   end

endmodule

// File: rtl/seq_ctrl.sv
// rtl/seq_ctrl.sv - run/halt/step sequencer and next-address control
module seq_ctrl
   import td4_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       step,
   input  logic       halt_req,
   input  logic [7:0] inst,
   input  logic [3:0] pc,
   input  logic       carry_in,
   output logic       isjump,
   output logic [3:0] jumpadrs,
   output logic       we_a,
   output logic       we_b,
   output logic       we_out,
   output logic [1:0] src_sel,
   output logic       cflag,
   output logic       halted,
   output logic       done,
   output logic       illegal
);

   state_t     state;
   state_t     state_next;
   logic       exec;
   logic       self_jump;
   logic       dec_we_a;
   logic       dec_we_b;
   logic       dec_we_out;
   logic [1:0] dec_src_sel;
   logic       jump_taken;
   logic       illegal_op;

   inst_decode u_decode (
      .op         (inst[7:4]),
      .cflag      (cflag),
      .we_a       (dec_we_a),
      .we_b       (dec_we_b),
      .we_out     (dec_we_out),
      .src_sel    (dec_src_sel),
      .jump_taken (jump_taken),
      .illegal_op (illegal_op)
   );

   // State register; reset lands in HALT and drops any instruction in flight
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_HALT;
      end else begin
         state <= state_next;
      end
   end

   // Next state plus output mux; when not executing the PC reloads itself
   always_comb begin
      state_next = state;
      exec       = (state == ST_RUN) || (state == ST_STEP);
      self_jump  = exec && jump_taken && (inst[3:0] == pc);
      isjump     = 1'b1;
      jumpadrs   = pc;
      we_a       = 1'b0;
      we_b       = 1'b0;
      we_out     = 1'b0;
      src_sel    = SRC_ZERO;
      halted     = (state == ST_HALT);
      case (state)
         ST_HALT: begin
            if (run) begin
               state_next = ST_RUN;
            end else if (step) begin
               state_next = ST_STEP;
            end
         end
         ST_RUN: begin
            if (self_jump || halt_req) begin
               state_next = ST_HALT;
            end
         end
         default: state_next = ST_HALT;
      endcase
      if (exec) begin
         isjump   = jump_taken;
         jumpadrs = inst[3:0];
         we_a     = dec_we_a;
         we_b     = dec_we_b;
         we_out   = dec_we_out;
         src_sel  = dec_src_sel;
      end
   end

   // Carry and sticky flags update only when an instruction retires
   always_ff @(posedge clk) begin
      if (!rst) begin
         cflag   <= 1'b0;
         done    <= 1'b0;
         illegal <= 1'b0;
      end else begin
         if (exec) begin
            cflag <= carry_in;
         end
         if (self_jump) begin
            done <= 1'b1;
         end else if ((state == ST_HALT) && (state_next != ST_HALT)) begin
            done <= 1'b0;
         end
         if (exec && illegal_op) begin
            illegal <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seq_ctrl.sv
// tb/tb_seq_ctrl.sv - directed scoreboard bench for seq_ctrl with a PC/ROM/ALU model
module tb_seq_ctrl;

   logic       clk;
   logic       rst;
   logic       run;
   logic       step;
   logic       halt_req;
   logic [7:0] inst;
   logic [3:0] pc;
   logic       carry_in;
   logic       isjump;
   logic [3:0] jumpadrs;
   logic       we_a;
   logic       we_b;
   logic       we_out;
   logic [1:0] src_sel;
   logic       cflag;
   logic       halted;
   logic       done;
   logic       illegal;

   logic [7:0] rom [16];
   logic [3:0] reg_a;
   logic [3:0] reg_b;
   logic [3:0] operand;
   logic [4:0] sum;

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;

   exp_t sbq[$];
   int   passed;
   int   total;

   seq_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .step     (step),
      .halt_req (halt_req),
      .inst     (inst),
      .pc       (pc),
      .carry_in (carry_in),
      .isjump   (isjump),
      .jumpadrs (jumpadrs),
      .we_a     (we_a),
      .we_b     (we_b),
      .we_out   (we_out),
      .src_sel  (src_sel),
      .cflag    (cflag),
      .halted   (halted),
      .done     (done),
      .illegal  (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign inst = rom[pc];

   // ALU model: operand source plus immediate, carry only for the ADD opcodes
   always_comb begin
      case (src_sel)
         2'd0:    operand = reg_a;
         2'd1:    operand = reg_b;
         2'd2:    operand = 4'h9;
         default: operand = 4'h0;
      endcase
      sum      = {1'b0, operand} + {1'b0, inst[3:0]};
      carry_in = ((inst[7:4] == 4'b0000) || (inst[7:4] == 4'b0101)) ? sum[4] : 1'b0;
   end

   // PC counter, selector and registers of the fetch/execute datapath
   always @(posedge clk) begin
      if (!rst) begin
         pc    <= 4'd0;
         reg_a <= 4'd0;
         reg_b <= 4'd0;
      end else begin
         pc <= isjump ? jumpadrs : pc + 4'd1;
         if (we_a) reg_a <= sum[3:0];
         if (we_b) reg_b <= sum[3:0];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_push(input string tag, input logic [15:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sbq.push_back(e);
   endtask

   task automatic sb_check(input logic [15:0] obs);
      exp_t e;
      total++;
      if (sbq.size() == 0) begin
         $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
      end else begin
         e = sbq.pop_front();
         assert (obs === e.val) passed++;
         else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic wait_pc(input logic [3:0] target);
      int n;
      n = 0;
      while (pc != target && n < 40) begin
         tick();
         n++;
      end
      total++;
      assert (n < 40) passed++;
      else $error("FAIL wait_pc: observed pc %0h required %0h within 40 cycles", pc, target);
   endtask

   initial begin
      passed = 0;
      total  = 0;
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
      do_reset();

      // reset state
      sb_push("rst_halted", 16'd1); sb_push("rst_isjump", 16'd1);
      sb_push("rst_jumpadrs", 16'd0); sb_push("rst_we", 16'd0);
      sb_push("rst_src_sel", 16'd3); sb_push("rst_flags", 16'd0);
      @(negedge clk);
      sb_check(16'(halted)); sb_check(16'(isjump)); sb_check(16'(jumpadrs));
      sb_check(16'({we_a, we_b, we_out})); sb_check(16'(src_sel));
      sb_check(16'({cflag, done, illegal}));
      for (int i = 0; i < 5; i++) begin
         tick();
         sb_push("idle_pc", 16'd0); sb_push("idle_we", 16'd0);
         @(negedge clk);
         sb_check(16'(pc)); sb_check(16'({we_a, we_b, we_out}));
      end

      // MOV A,3; ADD A,15; JNC 0 (falls through); JMP 3 (self-jump)
      rom[0] = 8'h33; rom[1] = 8'h0F; rom[2] = 8'hE0; rom[3] = 8'hF3;
      run = 1'b1;
      tick();
      run = 1'b0;
      sb_push("p1_pc0", 16'd0); sb_push("p1_we_mov", 16'b100); sb_push("p1_src_mov", 16'd3);
      @(negedge clk);
      sb_check(16'(pc)); sb_check(16'({we_a, we_b, we_out})); sb_check(16'(src_sel));
      tick();
      sb_push("p1_pc1", 16'd1); sb_push("p1_we_add", 16'b100); sb_push("p1_src_add", 16'd0);
      @(negedge clk);
      sb_check(16'(pc)); sb_check(16'({we_a, we_b, we_out})); sb_check(16'(src_sel));
      tick();
      sb_push("p1_pc2", 16'd2); sb_push("p1_cflag_after_add", 16'd1); sb_push("p1_jnc_not_taken", 16'd0);
      @(negedge clk);
      sb_check(16'(pc)); sb_check(16'(cflag)); sb_check(16'(isjump));
      tick();
      sb_push("p1_pc3", 16'd3); sb_push("p1_jmp_isjump", 16'd1); sb_push("p1_jmp_adrs", 16'd3);
      @(negedge clk);
      sb_check(16'(pc)); sb_check(16'(isjump)); sb_check(16'(jumpadrs));
      tick();
      sb_push("p1_halted", 16'd1); sb_push("p1_done", 16'd1); sb_push("p1_pc_end", 16'd3);
      @(negedge clk);
      sb_check(16'(halted)); sb_check(16'(done)); sb_check(16'(pc));
      tick();
      tick();
      sb_push("p1_pc_hold", 16'd3);
      @(negedge clk);
      sb_check(16'(pc));

      // JNC taken with cflag=0
      do_reset();
      rom[0] = 8'h31; rom[1] = 8'h00; rom[2] = 8'hE5; rom[3] = 8'h00;
      rom[4] = 8'h00; rom[5] = 8'hF5;
      run = 1'b1;
      tick();
      run = 1'b0;
      tick();
      tick();
      sb_push("p2_pc2", 16'd2); sb_push("p2_cflag0", 16'd0);
      sb_push("p2_jnc_isjump", 16'd1); sb_push("p2_jnc_adrs", 16'd5);
      @(negedge clk);
      sb_check(16'(pc)); sb_check(16'(cflag)); sb_check(16'(isjump)); sb_check(16'(jumpadrs));
      tick();
      sb_push("p2_pc5", 16'd5);
      @(negedge clk);
      sb_check(16'(pc));
      tick();
      sb_push("p2_done", 16'd1); sb_push("p2_halted", 16'd1);
      @(negedge clk);
      sb_check(16'(done)); sb_check(16'(halted));
      // leaving HALT by step clears done
      rom[5] = 8'h31;
      step = 1'b1;
      tick();
      step = 1'b0;
      sb_push("p2_step_running", 16'd0); sb_push("p2_done_cleared", 16'd0);
      @(negedge clk);
      sb_check(16'(halted)); sb_check(16'(done));
      tick();
      sb_push("p2_step_halt", 16'd1); sb_push("p2_step_pc6", 16'd6);
      @(negedge clk);
      sb_check(16'(halted)); sb_check(16'(pc));

      // single step three times, 4 cycles apart
      do_reset();
      rom[0] = 8'h35; rom[1] = 8'h72; rom[2] = 8'h90; rom[3] = 8'h00;
      for (int k = 0; k < 3; k++) begin
         step = 1'b1;
         tick();
         step = 1'b0;
         sb_push("st_exec", 16'd0); sb_push("st_pc", 16'(k));
         sb_push("st_we", (k == 0) ? 16'b100 : (k == 1) ? 16'b010 : 16'b001);
         @(negedge clk);
         sb_check(16'(halted)); sb_check(16'(pc)); sb_check(16'({we_a, we_b, we_out}));
         tick();
         sb_push("st_halt", 16'd1); sb_push("st_pc_next", 16'(k + 1)); sb_push("st_we_idle", 16'd0);
         @(negedge clk);
         sb_check(16'(halted)); sb_check(16'(pc)); sb_check(16'({we_a, we_b, we_out}));
         tick();
         tick();
         sb_push("st_pc_hold", 16'(k + 1));
         @(negedge clk);
         sb_check(16'(pc));
      end

      // halt_req at pc=6, then resume
      do_reset();
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
      run = 1'b1;
      tick();
      run = 1'b0;
      wait_pc(4'd6);
      halt_req = 1'b1;
      sb_push("hr_running", 16'd0);
      @(negedge clk);
      sb_check(16'(halted));
      tick();
      halt_req = 1'b0;
      sb_push("hr_halted", 16'd1); sb_push("hr_pc7", 16'd7);
      @(negedge clk);
      sb_check(16'(halted)); sb_check(16'(pc));
      tick();
      sb_push("hr_pc_hold", 16'd7);
      @(negedge clk);
      sb_check(16'(pc));
      run = 1'b1;
      tick();
      run = 1'b0;
      sb_push("hr_resumed", 16'd0); sb_push("hr_resume_pc", 16'd7);
      @(negedge clk);
      sb_check(16'(halted)); sb_check(16'(pc));
      tick();
      sb_push("hr_pc8", 16'd8);
      @(negedge clk);
      sb_check(16'(pc));

      // illegal opcode, then reset mid-run
      do_reset();
      rom[0] = 8'h3F; rom[4] = 8'hA0; rom[5] = 8'h0F;
      run = 1'b1;
      tick();
      run = 1'b0;
      wait_pc(4'd4);
      sb_push("il_we", 16'd0); sb_push("il_isjump", 16'd0); sb_push("il_before", 16'd0);
      @(negedge clk);
      sb_check(16'({we_a, we_b, we_out})); sb_check(16'(isjump)); sb_check(16'(illegal));
      tick();
      sb_push("il_pc5", 16'd5); sb_push("il_set", 16'd1);
      @(negedge clk);
      sb_check(16'(pc)); sb_check(16'(illegal));
      tick();
      sb_push("il_sticky", 16'd1); sb_push("il_cflag", 16'd1);
      @(negedge clk);
      sb_check(16'(illegal)); sb_check(16'(cflag));
      rst = 1'b0;
      tick();
      sb_push("mr_halted", 16'd1); sb_push("mr_illegal", 16'd0);
      sb_push("mr_cflag", 16'd0); sb_push("mr_pc", 16'd0);
      @(negedge clk);
      sb_check(16'(halted)); sb_check(16'(illegal)); sb_check(16'(cflag)); sb_check(16'(pc));
      rst = 1'b1;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
